// File: rtl/cfg_types_pkg.sv
// Shared types and constants for the Keccak memory loader.
package cfg_types_pkg;

    localparam int KECCAK_LANE_W         = 64;
    localparam int KECCAK_RATE_LANES_256 = 17;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_INIT   = 3'd1,
        LDR_FETCH  = 3'd2,
        LDR_PUSH   = 3'd3,
        LDR_ABS_HI = 3'd4,
        LDR_ABS_LO = 3'd5,
        LDR_FIN    = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/ldr_addr_gen.sv
// Lane/block counters and the wrapped RAM address adder for the loader.
// Addresses are produced from next-cycle counter values so the top can register them.
module ldr_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int RATE_LANES = 17,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base_in,
    input  logic [BLK_CNT_W-1:0]  nblk_in,
    input  logic                  lane_inc,
    input  logic                  lane_clr,
    input  logic                  blk_inc,
    output logic                  lane_last,
    output logic                  blk_last,
    output logic                  nblk_zero,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b
);

    localparam int LANE_W = $clog2(RATE_LANES);

    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [BLK_CNT_W-1:0]  blk_q, blk_d;
    logic [BLK_CNT_W-1:0]  nblk_q, nblk_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] index_s;

    // Counter and latched-parameter next state.
    always_comb begin
        lane_d = lane_q;
        blk_d  = blk_q;
        nblk_d = nblk_q;
        base_d = base_q;
        if (load) begin
            lane_d = {LANE_W{1'b0}};
            blk_d  = {BLK_CNT_W{1'b0}};
            nblk_d = nblk_in;
            base_d = base_in;
        end else begin
            if (lane_clr) begin
                lane_d = {LANE_W{1'b0}};
            end else if (lane_inc) begin
                lane_d = lane_q + LANE_W'(1'b1);
            end else begin
                lane_d = lane_q;
            end
            if (blk_inc) begin
                blk_d = blk_q + BLK_CNT_W'(1'b1);
            end else begin
                blk_d = blk_q;
            end
        end
    end

    // Lane index and byte address; all sums wrap at the address width.
    always_comb begin
        index_s = ADDR_WIDTH'(blk_d) * ADDR_WIDTH'(RATE_LANES) + ADDR_WIDTH'(lane_d);
        addr_a  = base_d + (index_s << 3);
        addr_b  = addr_a + ADDR_WIDTH'(3'd4);
    end

    assign lane_last = (lane_q == LANE_W'(RATE_LANES - 1));
    assign blk_last  = (blk_q == (nblk_q - BLK_CNT_W'(1'b1)));
    assign nblk_zero = (nblk_q == {BLK_CNT_W{1'b0}});

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= {LANE_W{1'b0}};
            blk_q  <= {BLK_CNT_W{1'b0}};
            nblk_q <= {BLK_CNT_W{1'b0}};
            base_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            lane_q <= lane_d;
            blk_q  <= blk_d;
            nblk_q <= nblk_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/keccak_mem_loader.sv
// Feeds rate blocks from dual-port RAM into the Keccak coprocessor, one 64-bit lane
// per two cycles, pacing each block on the coprocessor's buffer_full handshake.
module keccak_mem_loader
    import cfg_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RATE_LANES = KECCAK_RATE_LANES_256,
    parameter int BLK_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [BLK_CNT_W-1:0]    num_blocks,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_en_a,
    output logic                    mem_en_b,
    output logic [ADDR_WIDTH-1:0]   mem_addr_a,
    output logic [ADDR_WIDTH-1:0]   mem_addr_b,
    output logic                    mem_we_a,
    output logic                    mem_we_b,
    output logic [DATA_WIDTH-1:0]   mem_wdata_a,
    output logic [DATA_WIDTH-1:0]   mem_wdata_b,
    output logic [DATA_WIDTH/8-1:0] mem_be_a,
    output logic [DATA_WIDTH/8-1:0] mem_be_b,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_a,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_b,
    output logic                    core_start,
    output logic [2*DATA_WIDTH-1:0] din,
    output logic                    din_valid,
    output logic                    last_block,
    input  logic                    buffer_full
);

    ldr_state_t state_q, state_d;

    logic load_s, lane_inc_s, lane_clr_s, blk_inc_s;
    logic lane_last_s, blk_last_s, nblk_zero_s;
    logic [ADDR_WIDTH-1:0] addr_a_s, addr_b_s;

    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic core_start_q, core_start_d, mem_en_q, mem_en_d;
    logic din_valid_q, din_valid_d, last_block_q, last_block_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_a_q, mem_addr_a_d, mem_addr_b_q, mem_addr_b_d;
    logic [2*DATA_WIDTH-1:0] din_q, din_d;

    ldr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RATE_LANES (RATE_LANES),
        .BLK_CNT_W  (BLK_CNT_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .base_in   (base_addr),
        .nblk_in   (num_blocks),
        .lane_inc  (lane_inc_s),
        .lane_clr  (lane_clr_s),
        .blk_inc   (blk_inc_s),
        .lane_last (lane_last_s),
        .blk_last  (blk_last_s),
        .nblk_zero (nblk_zero_s),
        .addr_a    (addr_a_s),
        .addr_b    (addr_b_s)
    );

    // Next-state logic and counter controls.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        lane_inc_s = 1'b0;
        lane_clr_s = 1'b0;
        blk_inc_s  = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (start) begin
                    state_d = LDR_INIT;
                    load_s  = 1'b1;
                end else begin
                    state_d = LDR_IDLE;
                end
            end
            LDR_INIT:  state_d = nblk_zero_s ? LDR_FIN : LDR_FETCH;
            LDR_FETCH: state_d = LDR_PUSH;
            LDR_PUSH: begin
                if (lane_last_s) begin
                    lane_clr_s = 1'b1;
                    state_d    = LDR_ABS_HI;
                end else begin
                    lane_inc_s = 1'b1;
                    state_d    = LDR_FETCH;
                end
            end
            LDR_ABS_HI: begin
                if (buffer_full) begin
                    state_d = LDR_ABS_LO;
                end else begin
                    state_d = LDR_ABS_HI;
                end
            end
            LDR_ABS_LO: begin
                if (!buffer_full) begin
                    if (blk_last_s) begin
                        state_d = LDR_FIN;
                    end else begin
                        blk_inc_s = 1'b1;
                        state_d   = LDR_FETCH;
                    end
                end else begin
                    state_d = LDR_ABS_LO;
                end
            end
            LDR_FIN: state_d = LDR_IDLE;
            default: state_d = LDR_IDLE;
        endcase
    end

    // Output register next values. done trails FIN by a cycle, so busy is stretched over it.
    always_comb begin
        busy_d       = (state_d != LDR_IDLE) || (state_q == LDR_FIN);
        done_d       = (state_q == LDR_FIN);
        core_start_d = load_s && (num_blocks != {BLK_CNT_W{1'b0}});
        if (load_s) begin
            err_d = 1'b0;
        end else if ((state_q == LDR_INIT) && nblk_zero_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        mem_en_d = (state_d == LDR_FETCH);
        if (mem_en_d) begin
            mem_addr_a_d = addr_a_s;
            mem_addr_b_d = addr_b_s;
        end else begin
            mem_addr_a_d = mem_addr_a_q;
            mem_addr_b_d = mem_addr_b_q;
        end
        din_valid_d = (state_q == LDR_PUSH);
        if (state_q == LDR_PUSH) begin
            din_d        = {mem_rdata_b, mem_rdata_a};
            last_block_d = blk_last_s;
        end else begin
            din_d        = din_q;
            last_block_d = last_block_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LDR_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_addr_a_q <= {ADDR_WIDTH{1'b0}};
            mem_addr_b_q <= {ADDR_WIDTH{1'b0}};
            din_valid_q  <= 1'b0;
            last_block_q <= 1'b0;
            din_q        <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            mem_en_q     <= mem_en_d;
            mem_addr_a_q <= mem_addr_a_d;
            mem_addr_b_q <= mem_addr_b_d;
            din_valid_q  <= din_valid_d;
            last_block_q <= last_block_d;
            din_q        <= din_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign core_start  = core_start_q;
    assign mem_en_a    = mem_en_q;
    assign mem_en_b    = mem_en_q;
    assign mem_addr_a  = mem_addr_a_q;
    assign mem_addr_b  = mem_addr_b_q;
    assign din_valid   = din_valid_q;
    assign last_block  = last_block_q;
    assign din         = din_q;
    assign mem_we_a    = 1'b0;
    assign mem_we_b    = 1'b0;
    assign mem_wdata_a = {DATA_WIDTH{1'b0}};
    assign mem_wdata_b = {DATA_WIDTH{1'b0}};
    assign mem_be_a    = {(DATA_WIDTH/8){1'b1}};
    assign mem_be_b    = {(DATA_WIDTH/8){1'b1}};

endmodule
